// File: rtl/e203_flush_pkg.sv
// Shared encodings for the EXU flush scheduler slice.
package e203_flush_pkg;

  typedef enum logic {
    FS_IDLE = 1'b0,
    FS_PEND = 1'b1
  } fs_state_e;

  typedef enum logic {
    SRC_BRCH = 1'b0,
    SRC_EXCP = 1'b1
  } flush_src_e;

endpackage

// File: rtl/e203_sat_cnt.sv
// Saturating event counter: holds at all-ones instead of wrapping.
module e203_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/e203_exu_flush_sched.sv
// Arbitrates exception vs branch-resolve flushes and holds one registered
// flush request toward the IFU until it is acknowledged.
module e203_exu_flush_sched #(
  parameter int unsigned PC_SIZE = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               excp_flush_req,
  input  logic [PC_SIZE-1:0] excp_flush_pc,
  output logic               excp_flush_ack,
  input  logic               brch_flush_req,
  input  logic [PC_SIZE-1:0] brch_flush_add_op1,
  input  logic [PC_SIZE-1:0] brch_flush_add_op2,
  output logic               brch_flush_ack,
  output logic               ifu_flush_req,
  output logic [PC_SIZE-1:0] ifu_flush_pc,
  input  logic               ifu_flush_ack,
  output logic               flush_busy,
  output logic               flush_src_excp,
  output logic [CNT_W-1:0]   brch_flush_cnt,
  output logic [CNT_W-1:0]   excp_flush_cnt
);

  import e203_flush_pkg::*;

  fs_state_e          r_state;
  flush_src_e         r_src;
  logic [PC_SIZE-1:0] r_pc;

  logic               w_idle;
  logic               w_override;
  logic               w_excp_ack;
  logic               w_brch_ack;
  logic [PC_SIZE-1:0] w_brch_tgt;

  assign w_idle     = (r_state == FS_IDLE);
  // A pending branch flush may be replaced by an exception, unless the IFU
  // is taking the branch target in this very cycle.
  assign w_override = (r_state == FS_PEND) && (r_src == SRC_BRCH) && !ifu_flush_ack;
  assign w_excp_ack = rst_n && excp_flush_req && (w_idle || w_override);
  assign w_brch_ack = rst_n && brch_flush_req && w_idle && !excp_flush_req;
  assign w_brch_tgt = brch_flush_add_op1 + brch_flush_add_op2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FS_IDLE;
      r_src   <= SRC_BRCH;
      r_pc    <= '0;
    end else begin
      case (r_state)
        FS_IDLE: begin
          if (w_excp_ack) begin
            r_state <= FS_PEND;
            r_src   <= SRC_EXCP;
            r_pc    <= excp_flush_pc;
          end else if (w_brch_ack) begin
            r_state <= FS_PEND;
            r_src   <= SRC_BRCH;
            r_pc    <= w_brch_tgt;
          end
        end
        FS_PEND: begin
          if (ifu_flush_ack) begin
            r_state <= FS_IDLE;
          end else if (w_excp_ack) begin
            r_src <= SRC_EXCP;
            r_pc  <= excp_flush_pc;
          end
        end
        default: r_state <= FS_IDLE;
      endcase
    end
  end

  assign excp_flush_ack = w_excp_ack;
  assign brch_flush_ack = w_brch_ack;
  assign ifu_flush_req  = (r_state == FS_PEND);
  assign ifu_flush_pc   = r_pc;
  assign flush_busy     = (r_state == FS_PEND);
  assign flush_src_excp = (r_state == FS_PEND) && (r_src == SRC_EXCP);

  e203_sat_cnt #(.W(CNT_W)) u_brch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_brch_ack),
    .cnt   (brch_flush_cnt)
  );

  e203_sat_cnt #(.W(CNT_W)) u_excp_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_excp_ack),
    .cnt   (excp_flush_cnt)
  );

endmodule

// File: doc/e203_exu_flush_sched.md
# e203_exu_flush_sched

Flush scheduler between the EXU flush sources and the IFU flush port. It arbitrates the branch-resolve flush (misprediction, fence.i, mret, dret) against the exception/interrupt flush, and accepts one flush at a time. It registers the target PC: the adder result for branch flushes, the direct PC for exceptions. It then holds the request to the IFU until acknowledged and keeps saturating flush statistics.

## Interface
Parameters:
- PC_SIZE, 32, width of all PC/operand buses
- CNT_W, 16, width of statistics counters

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- excp_flush_req  in  1  exception/IRQ flush request
- excp_flush_pc  in  PC_SIZE  exception target PC
- excp_flush_ack  out  1  exception request accepted this cycle
- brch_flush_req  in  1  branch-resolve flush request
- brch_flush_add_op1  in  PC_SIZE  target adder operand 1
- brch_flush_add_op2  in  PC_SIZE  target adder operand 2
- brch_flush_ack  out  1  branch request accepted this cycle
- ifu_flush_req  out  1  flush request to IFU
- ifu_flush_pc  out  PC_SIZE  flush target PC to IFU
- ifu_flush_ack  in  1  IFU accepts flush
- flush_busy  out  1  a flush is pending toward the IFU
- flush_src_excp  out  1  pending flush originated from exception
- brch_flush_cnt  out  CNT_W  branch flushes accepted, saturating
- excp_flush_cnt  out  CNT_W  exception flushes accepted, saturating

## Operation
- States: IDLE and PEND.
- IDLE:
  - Excp has priority: if excp_flush_req, then excp_flush_ack=1 (combinational), latch excp_flush_pc, set src=EXCP, go to PEND.
  - Else if brch_flush_req, then brch_flush_ack=1, latch (op1+op2) mod 2^PC_SIZE with carry discarded, set src=BRCH, go to PEND.
  - Both requests high: only excp is acked; brch stays unacked and must be held by its requester.
- PEND:
  - ifu_flush_req=1 and ifu_flush_pc=latched PC; both are stable until the handshake.
  - On ifu_flush_ack, go to IDLE.
  - No new requests are acked in PEND, with one exception, the override below.
- Override: in PEND with src=BRCH, excp_flush_req=1 and ifu_flush_ack=0:
  - excp_flush_ack=1;
  - the latched PC is replaced by excp_flush_pc and src becomes EXCP;
  - the state stays PEND.
  - If ifu_flush_ack=1 in the same cycle, the branch flush completes and excp is not acked; it is served from IDLE next cycle.
- An excp flush in PEND is never overridden.
- Counters:
  - brch_flush_cnt increments on each brch ack.
  - excp_flush_cnt increments on each excp ack, including overrides.
  - An overridden branch flush stays counted.
  - Both saturate at all-ones.
- Outputs: flush_busy = (state==PEND); flush_src_excp = src when PEND, else 0.
- Reset, from any state including mid-PEND: state IDLE, ifu_flush_req 0, ifu_flush_pc 0, src BRCH, both counters 0. No ack is generated in the reset cycle.

## Timing
- Accept in cycle N → ifu_flush_req=1 from cycle N+1.
- Minimum interval between accepts is 2 cycles: accept, then IFU ack, then IDLE.
- The acks are combinational from requests and state. The IFU-side outputs are registered only; there is no combinational path from ifu_flush_ack to ifu_flush_pc.
- An IFU ack with ifu_flush_req=0 is ignored.
- The branch target addition is done once, at accept.

## Structure
- Shared package e203_flush_pkg:
  - state encoding FS_IDLE=1'b0, FS_PEND=1'b1;
  - source encoding SRC_BRCH=1'b0, SRC_EXCP=1'b1.
- One sub-module e203_sat_cnt (parameter W; inputs inc, clk, rst_n; output cnt), instantiated twice.

## Test plan
- Branch-only: op1=0x8000_0100, op2=0x0000_0040, req cycle 0. Required: ack cycle 0; ifu_flush_req from cycle 1 with pc 0x8000_0140; IFU ack cycle 3 gives busy=0 cycle 4; brch_flush_cnt=1.
- Simultaneous: both requests in cycle 0, excp_pc=0x100. Required: excp acked, brch not acked; ifu_flush_pc=0x100; brch acked the cycle after the IFU ack.
- Override: branch flush pending toward 0x200, excp request (pc 0x300) with ifu_flush_ack=0. Required: excp ack; pc becomes 0x300, src=EXCP; both counters=1.
- Override race: in the same scenario, assert ifu_flush_ack with excp_req. Required: IFU takes 0x200, excp not acked; excp accepted next cycle.
- Wrap and saturation:
  - op1=0xFFFF_FFFC, op2=0x8 gives pc 0x4.
  - Preload by 65535 accepts; the next accept holds brch_flush_cnt at 0xFFFF.
- Reset mid-PEND: assert rst_n=0. Required: next cycle ifu_flush_req=0, pc=0, counters=0; no ack in the reset cycle.
